uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter that succeeds the fixed 8N1 transmit block. It is configurable in data width, parity mode, stop-bit count and input FIFO depth. Bytes are written into an internal FIFO and serialised LSB-first on `txd`. Bit boundaries are paced by an external baud strobe from the shared baud generator. The block sits between the bus-side register interface (write port, status flags) and the serial pin.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; 1 or 2
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- baud_tick  in  1  one-cycle strobe, one per bit period
- wr_en  in  1  write request for wr_data
- wr_data  in  DATA_BITS  payload to enqueue
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- overflow  out  1  one-cycle pulse when a write is dropped
- busy  out  1  a frame is on the line (state != IDLE)
- frame_start  out  1  one-cycle pulse on the cycle a frame is popped
- tbr  out  1  transmitter empty: empty && !busy
- txd  out  1  serial output, registered, idles high

## Operation
- One clock domain (`clk`). Reset is synchronous and active-high (`rst`), with no asynchronous path.
- Reset values: txd=1, full=0, empty=1, overflow=0, busy=0, frame_start=0, tbr=1. State is IDLE, FIFO pointers are 0 and FIFO contents are cleared.
- Reset asserted mid-frame aborts the frame, drives txd=1 on the next edge and discards all FIFO contents.
- FIFO:
  - A write is accepted when wr_en is high and either !full, or a pop occurs in the same cycle.
  - A write with wr_en high while full and no pop is dropped; overflow pulses for one cycle. FIFO contents are unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full and empty are derived from the pointers and are registered-accurate in the cycle after the update.
- States and transitions (transitions happen only on baud_tick; otherwise the state holds):
  - IDLE: txd=1. On baud_tick with !empty: pop the head, load the shifter, pulse frame_start, go to START.
  - START: txd=0. On tick: go to DATA with bit index 0.
  - DATA: txd=shift[0]. On each tick, shift right and increment the bit index.
    - After DATA_BITS ticks, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: txd = ^data for even, ~^data for odd. On tick: go to STOP.
  - STOP: txd=1, lasting STOP_BITS ticks. On the final stop tick:
    - if !empty: pop, pulse frame_start and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Parity is computed over the popped word at load time and stored with it.
- A frame is exactly 1+DATA_BITS+(PARITY!=0)+STOP_BITS baud periods.
- baud_tick while IDLE and empty has no effect.
- wr_en while busy only enqueues; it never disturbs the frame in flight.

## Timing
- txd is registered. The level for a state appears on the clk edge that enters that state, so it changes 1 cycle after the baud_tick that caused the transition.
- Write to line: if a word is written into an idle, empty block at cycle t, empty deasserts at t+1. The first baud_tick at cycle ≥ t+1 pops the word, and txd falls on the following edge.
- frame_start and the pop occur in the same cycle as the launching baud_tick.
- A pop in the same cycle as a write to a full FIFO accepts the write; full stays 1.
- busy rises with the START entry edge and falls with the IDLE entry edge.
- tbr rises in the cycle IDLE is entered with empty=1.

## Test plan
- Reset: assert rst for 2 cycles mid-frame -> next edge shows txd=1, tbr=1, empty=1, busy=0; no further txd activity.
- Frame format: DATA_BITS=8, PARITY=2, STOP_BITS=1, write 0xA5, ticks every 16 clks.
  - txd per tick = 0,1,0,1,0,0,1,0,1,0(parity),1 -> 11 bit periods, then tbr=1.
- Odd parity, two stops: DATA_BITS=7, PARITY=1, STOP_BITS=2, write 0x03 -> parity bit 1; two stop periods of txd=1.
- Back-to-back: write 0x55 and 0xAA on consecutive cycles.
  - Second start bit immediately follows the first frame's stop bit, with no idle period.
  - frame_start pulses twice, exactly 10 ticks apart (8N1).
- Overflow: FIFO_DEPTH=4, no ticks, write 5 words.
  - full=1 after 4 writes; the 5th pulses overflow=1 for one cycle.
  - Ticks then transmit exactly the first 4 words, in order.
- Simultaneous write/pop at full: FIFO full, write on the launching baud_tick -> write accepted, overflow=0, full stays 1, and 5 frames are emitted in total.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small FIFO.
// Words written on the bus side are queued and sent LSB-first on txd. The
// line advances only on baud_tick. Frames launch back-to-back when the FIFO
// is non-empty at the final stop tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 tbr,
  output logic                 txd
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LastIdx = IW'(DATA_BITS - 1);
  localparam logic LastStop = (STOP_BITS == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 txd_q, txd_d;
  logic                 overflow_q, overflow_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 last_stop;
  logic                 pop;
  logic                 push;

  // Extra pointer bit tells full (same slot, different lap) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Parity is fixed at pop time and travels with the word in par_q.
  assign head_par = (PARITY == 1) ? ~^head : ^head;

  assign last_stop = (state_q == StStop) && (stop_cnt_q == LastStop);
  assign pop       = !rst && baud_tick && !empty && ((state_q == StIdle) || last_stop);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push       = wr_en && (!full || pop);
  assign overflow_d = wr_en && !push;

  assign overflow    = overflow_q;
  assign busy        = (state_q != StIdle);
  assign frame_start = pop;
  assign tbr         = empty && !busy;
  assign txd         = txd_q;

  // FIFO next state: pointer advance and slot write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Frame sequencer next state; txd_d is the level of the state being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    if (baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_d = StStart;
            shift_d = head;
            par_d   = head_par;
            txd_d   = 1'b0;
          end
        end
        StStart: begin
          state_d = StData;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
        StData: begin
          if (idx_q == LastIdx) begin
            if (PARITY != 0) begin
              state_d = StParity;
              txd_d   = par_q;
            end else begin
              state_d    = StStop;
              stop_cnt_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            txd_d   = shift_q[1];
          end
        end
        StParity: begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
        StStop: begin
          if (stop_cnt_q == LastStop) begin
            if (pop) begin
              // Next word waiting: start bit follows the last stop bit directly.
              state_d = StStart;
              shift_d = head;
              par_d   = head_par;
              txd_d   = 1'b0;
            end else begin
              state_d = StIdle;
              txd_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  // Frame sequencer state and registered line/overflow outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
